// File: rtl/shift_accum_pkg.sv
// shift_accum_pkg: request types shared with the accumulator and reader FSM states
package shift_accum_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} accum_request_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} reader_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head; push and pop may coincide when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign rd = pop && !empty;
    assign wr = push && (!full || rd);
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/shift_accum_reader.sv
// shift_accum_reader: sweeps an address window of the accumulator and streams the read words
module shift_accum_reader
    import shift_accum_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic [$clog2(DEPTH)-1:0]   base_addr_in,
    input  logic [$clog2(DEPTH):0]     count_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [$clog2(DEPTH)-1:0]   req_addr_out,
    output logic                       req_summand_out,
    output accum_request_t             req_type_out,
    output logic                       req_valid_out,
    input  logic [WIDTH-1:0]           rsp_data_in,
    input  logic [$clog2(DEPTH)-1:0]   rsp_addr_in,
    input  accum_request_t             rsp_type_in,
    input  logic                       rsp_valid_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH)-1:0]   addr_out,
    output logic                       last_out,
    output logic                       valid_out,
    input  logic                       ready_in
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = WIDTH + AW + 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW:0] CREDITS = (OW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < LATENCY + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least LATENCY+1");
    end

    reader_state_t state, state_nxt;
    logic [CW-1:0] count_q, issued, pushed;
    logic [AW-1:0] addr_q;
    logic [OW-1:0] outstanding, fifo_count;
    logic [FW-1:0] head;
    logic issue, accept, pop, fifo_empty, fifo_full;

    assign req_summand_out = 1'b0;
    assign req_type_out = READ;
    assign valid_out = !fifo_empty;
    assign pop = valid_out && ready_in;
    assign {data_out, addr_out, last_out} = valid_out ? head : '0;
    // Responses in flight plus buffered words may never exceed the buffer size
    assign issue = (state == ISSUE) && (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
    assign accept = rsp_valid_in && (rsp_type_in == READ) && (outstanding != '0);

    always_comb begin
        state_nxt = state;
        busy_out = (state == ISSUE) || (state == DRAIN);
        done_out = state == DONE;
        unique case (state)
            IDLE:  if (start_in) state_nxt = (count_in == '0) ? DONE : ISSUE;
            ISSUE: if (issue && issued == count_q - 1'b1) state_nxt = DRAIN;
            DRAIN: if (pop && head[0]) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            count_q <= '0;
            issued <= '0;
            pushed <= '0;
            addr_q <= '0;
            outstanding <= '0;
            req_valid_out <= 1'b0;
            req_addr_out <= '0;
        end else begin
            state <= state_nxt;
            req_valid_out <= issue;
            if (issue) req_addr_out <= addr_q;
            outstanding <= outstanding + OW'(issue) - OW'(accept);
            if (state == IDLE && start_in) begin
                count_q <= count_in;
                addr_q <= base_addr_in;
                issued <= '0;
                pushed <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + 1'b1;
                    addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                end
                if (accept) pushed <= pushed + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) assert (!(accept && fifo_full)) else $error("output buffer overflow");
    end

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_in),
        .rst(rst_in),
        .push(accept),
        .push_data({rsp_data_in, rsp_addr_in, pushed == count_q - 1'b1}),
        .pop(pop),
        .pop_data(head),
        .empty(fifo_empty),
        .full(fifo_full),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_shift_accum_reader.sv
// tb_shift_accum_reader: directed sweeps against a two-cycle accumulator model
module tb_shift_accum_reader;
    import shift_accum_pkg::*;
    logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, ready_in = 1'b0, inj = 1'b0;
    logic [9:0] base_addr_in = '0, req_addr_out, rsp_addr_in, addr_out;
    logic [10:0] count_in = '0;
    logic busy_out, done_out, req_summand_out, req_valid_out, rsp_valid_in, last_out, valid_out;
    logic [31:0] rsp_data_in, data_out;
    accum_request_t req_type_out, rsp_type_in;
    logic v1 = 1'b0, v2 = 1'b0;
    logic [9:0] a1 = '0, a2 = '0;
    int checks = 0, failures = 0;

    shift_accum_reader dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .base_addr_in(base_addr_in),
        .count_in(count_in), .busy_out(busy_out), .done_out(done_out), .req_addr_out(req_addr_out),
        .req_summand_out(req_summand_out), .req_type_out(req_type_out), .req_valid_out(req_valid_out),
        .rsp_data_in(rsp_data_in), .rsp_addr_in(rsp_addr_in), .rsp_type_in(rsp_type_in),
        .rsp_valid_in(rsp_valid_in), .data_out(data_out), .addr_out(addr_out), .last_out(last_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Accumulator model: fixed two-cycle read latency; inj drives WRITE traffic into idle bus slots
    always @(posedge clk_in) begin
        v1 <= req_valid_out;
        a1 <= req_addr_out;
        v2 <= v1;
        a2 <= a1;
    end
    always_comb begin
        rsp_valid_in = v2 | inj;
        rsp_type_in = v2 ? READ : WRITE;
        rsp_addr_in = v2 ? a2 : 10'h155;
        rsp_data_in = v2 ? (32'hA000_0000 | {22'd0, a2}) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sweep(input int base, input int cnt, input int stall, input bit toggle, input bit inj_en);
        int k, reqs, rsps, ea;
        bit exp_done, saw_done;
        logic [9:0] ea10;
        k = 0; reqs = 0; rsps = 0; exp_done = (cnt == 0); saw_done = 0;
        @(negedge clk_in);
        start_in = 1'b1; base_addr_in = 10'(base); count_in = 11'(cnt);
        for (int cyc = 0; cyc < 400 && !saw_done; cyc++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            ready_in = (cyc >= stall) && (!toggle || (cyc % 2 == 1));
            inj = inj_en && cyc < 30;
            if (req_valid_out) reqs++;
            if (v2) rsps++;
            if (stall > 0 && cyc == stall - 1) begin
                check("stall_reqs", 64'(reqs), 64'd4);
                check("stall_rsps", 64'(rsps), 64'd4);
                check("stall_valid", 64'(valid_out), 64'd1);
            end
            check("done", 64'(done_out), 64'(exp_done));
            check("busy", 64'(busy_out), 64'(cnt != 0 && !exp_done));
            saw_done = exp_done;
            if (valid_out && ready_in) begin
                ea = (base + k) % 1024;
                ea10 = 10'(ea);
                check($sformatf("word%0d", k), {data_out, addr_out, last_out},
                      {21'd0, 32'hA000_0000 | {22'd0, ea10}, ea10, k == cnt - 1});
                exp_done = (k == cnt - 1);
                k++;
            end
        end
        inj = 1'b0;
        check("words", 64'(k), 64'(cnt));
        check("reqs", 64'(reqs), 64'(cnt));
        check("finished", 64'(saw_done), 64'd1);
    endtask

    initial begin
        int k;
        bit bad;
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        check("reset", {busy_out, done_out, req_valid_out, req_addr_out, req_summand_out, req_type_out,
                        valid_out, data_out, addr_out, last_out}, 64'd0);
        sweep(0, 8, 0, 0, 0);
        check("req_type", {req_summand_out, req_type_out}, 64'd0);
        sweep(1022, 4, 0, 0, 0);
        sweep(512, 16, 20, 0, 0);
        sweep(7, 0, 0, 0, 0);
        sweep(100, 8, 0, 1, 1);
        @(negedge clk_in);
        start_in = 1'b1; base_addr_in = 10'h040; count_in = 11'd8;
        @(negedge clk_in);
        start_in = 1'b0; ready_in = 1'b1;
        k = 0;
        for (int c = 0; c < 50 && k < 2; c++) begin
            @(negedge clk_in);
            if (valid_out) k++;
        end
        check("rst_wait", 64'(k), 64'd2);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("abort", {busy_out, done_out, valid_out, req_valid_out}, 64'd0);
        bad = 0;
        repeat (6) begin
            @(negedge clk_in);
            bad |= valid_out | done_out | busy_out | req_valid_out;
        end
        check("stale_dropped", 64'(bad), 64'd0);
        sweep(5, 2, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
